cereal_rx: RTL and testbench

Serial receive path for the tweetboard: deserialises 8N1 frames arriving on the serial input line and stores each received byte as a 16-bit tagged word in the message RAM at an auto-incrementing address. It is the receiving counterpart of the `cereal` transmitter. It replaces ad-hoc bit capture in the top level with a mid-bit-sampling receiver that includes start-bit validation, framing-error detection and buffer-full handling.

---
 rtl/cereal_pkg.sv | 26 ++
 rtl/cereal_rx_if.sv | 45 ++++
 rtl/cereal_rx_sync2.sv | 31 +++
 rtl/cereal_rx.sv | 199 +++++++++++++++++++
 tb/tb_cereal_rx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cereal_pkg.sv
// cereal_pkg: shared definitions for the cereal transmitter and cereal_rx receiver.
// Honours CEREAL_RX_PARITY_EN (adds the PARITY state for 8E1 frames).
`default_nettype none

package cereal_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10417;

  localparam int VALID_BIT = 15;
  localparam int FERR_BIT  = 14;
  localparam int PERR_BIT  = 13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef CEREAL_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } cereal_state_e;

endpackage

`default_nettype wire

// File: rtl/cereal_rx_if.sv
// cereal_rx_if: serial line input plus message-RAM write port of the receiver.
// slave = receiver side, master = the side driving the line and consuming writes.
`default_nettype none

interface cereal_rx_if #(
  parameter int ADDR_W = 8
) ();

  logic              serial_in;
  logic              clear;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              byte_valid;
  logic              busy;
  logic              full;
  logic              overrun;

  modport master (
    output serial_in,
    output clear,
    input  ram_write,
    input  ram_addr,
    input  ram_data,
    input  byte_valid,
    input  busy,
    input  full,
    input  overrun
  );

  modport slave (
    input  serial_in,
    input  clear,
    output ram_write,
    output ram_addr,
    output ram_data,
    output byte_valid,
    output busy,
    output full,
    output overrun
  );

endinterface

`default_nettype wire

// File: rtl/cereal_rx_sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the value both stages take while reset is asserted.
`default_nettype none

module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/cereal_rx.sv
// cereal_rx: mid-bit sampling 8N1 receiver writing tagged bytes into the message RAM.
// Define CEREAL_RX_PARITY_EN for 8E1 frames with parity checking.
`default_nettype none

module cereal_rx
  import cereal_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int ADDR_W       = 8
) (
  input  wire logic  sysclk,
  input  wire logic  reset_n,
  cereal_rx_if.slave bus
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (sysclk),
    .rst_n (reset_n),
    .d     (bus.serial_in),
    .q     (rx_s)
  );

  cereal_state_e     state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [2:0]        bit_q,     bit_d;
  logic [7:0]        shift_q,   shift_d;
  logic              perr_q,    perr_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              full_q,    full_d;
  logic              overrun_q, overrun_d;
  logic              wr_q,      wr_d;
  logic              valid_q,   valid_d;
  logic [15:0]       data_q,    data_d;
  logic              busy_q,    busy_d;

  logic              frame_done;
  logic [15:0]       word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    addr_d     = addr_q;
    full_d     = full_q;
    overrun_d  = overrun_q;
    wr_d       = 1'b0;
    valid_d    = 1'b0;
    data_d     = data_q;
    frame_done = 1'b0;
    word       = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_M1;
          perr_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef CEREAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef CEREAL_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          perr_d  = rx_s ^ (^shift_q);
          cnt_d   = FULL_M1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == '0) begin
          frame_done = 1'b1;
          // A low stop bit may be a break; hold off until the line idles again.
          state_d    = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    word[VALID_BIT] = 1'b1;
    word[FERR_BIT]  = ~rx_s;
    word[PERR_BIT]  = perr_q;
    word[7:0]       = shift_q;

    // Address advances in the cycle after the strobe so ram_addr is stable during it.
    if (wr_q) begin
      addr_d = addr_q + 1'b1;
      if (addr_q == '1) begin
        full_d = 1'b1;
      end
    end

    if (frame_done) begin
      valid_d = 1'b1;
      if (!full_q) begin
        wr_d   = 1'b1;
        data_d = word;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (bus.clear) begin
      addr_d    = '0;
      full_d    = 1'b0;
      overrun_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      perr_q    <= 1'b0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_q      <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 16'h0000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      wr_q      <= wr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ram_write  = wr_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_data   = data_q;
  assign bus.byte_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.full       = full_q;
  assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_cereal_rx.sv
// tb_cereal_rx: scoreboard bench for cereal_rx with CLKS_PER_BIT=16, ADDR_W=2.
// Honours CEREAL_RX_PARITY_EN to send 8E1 frames and run the parity cases.
`default_nettype none

module tb_cereal_rx;

  localparam int CPB = 16;
  localparam int AW  = 2;
  localparam int H   = CPB / 2;
  localparam int N   = CPB;
`ifdef CEREAL_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = H + (PAR_EN ? 10 : 9) * N + 3;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cyc = 0;
  int   wr_cyc   = 0;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [AW-1:0] exp_addr;
  logic          exp_full;
  logic          exp_ovr;

  cereal_rx_if #(.ADDR_W(AW)) bus ();

  cereal_rx #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every completed frame is matched against the oldest scoreboard entry.
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (bus.ram_write && !bus.byte_valid)
        check("write_without_valid", 32'd1, 32'd0);
      if (bus.byte_valid) begin
        wr_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ram_write", bus.ram_write, mon_e.wr);
          if (mon_e.wr) begin
            check("ram_addr", bus.ram_addr, mon_e.addr);
            check("ram_data", bus.ram_data, mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    exp_t e;
    logic perr;
    perr   = PAR_EN ? (par_bit ^ (^b)) : 1'b0;
    e.data = {1'b1, ~stop_bit, perr, 5'b00000, b};
    e.addr = exp_addr;
    if (!exp_full) begin
      e.wr     = 1'b1;
      exp_addr = exp_addr + 1'b1;
      if (exp_addr == '0) exp_full = 1'b1;
    end else begin
      e.wr    = 1'b0;
      exp_ovr = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    push_exp(b, stop_bit, par_bit);
    bus.serial_in = 1'b0;
    edge_cyc      = cyc;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = b[i];
      tick(N);
    end
    if (PAR_EN) begin
      bus.serial_in = par_bit;
      tick(N);
    end
    bus.serial_in = stop_bit;
    tick(N);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    exp_addr  = '0;
    exp_full  = 1'b0;
    exp_ovr   = 1'b0;
    tick(1);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_addr"},    bus.ram_addr, exp_addr);
    check({tag, "_full"},    bus.full,     exp_full);
    check({tag, "_overrun"}, bus.overrun,  exp_ovr);
    check({tag, "_sb"},      sb.size(),    0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_write"},  bus.ram_write,  0);
    check({tag, "_ram_addr"},   bus.ram_addr,   0);
    check({tag, "_ram_data"},   bus.ram_data,   0);
    check({tag, "_byte_valid"}, bus.byte_valid, 0);
    check({tag, "_busy"},       bus.busy,       0);
    check({tag, "_full"},       bus.full,       0);
    check({tag, "_overrun"},    bus.overrun,    0);
  endtask

  logic [7:0] b;

  initial begin
    bus.serial_in = 1'b1;
    bus.clear     = 1'b0;
    exp_addr      = '0;
    exp_full      = 1'b0;
    exp_ovr       = 1'b0;

    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(5);

    // Single frame with exact write latency.
    send_frame(8'h41, 1'b1, 1'b0);
    check("single_latency", wr_cyc - edge_cyc, LAT);
    check("single_busy", bus.busy, 0);
    check_flags("single");

    // Short low glitch is rejected as a false start.
    bus.serial_in = 1'b0;
    tick(5);
    bus.serial_in = 1'b1;
    tick(3);
    check("glitch_busy_start", bus.busy, 1);
    tick(20);
    check("glitch_busy_end", bus.busy, 0);
    check_flags("glitch");

    // Framing error followed by a held-low line.
    b = 8'h55;
    send_frame(b, 1'b0, ^b);
    tick(40);
    check("break_busy", bus.busy, 1);
    check_flags("framing");
    bus.serial_in = 1'b1;
    tick(5);
    check("break_release_busy", bus.busy, 0);

    // Fill the RAM, then overrun, then clear.
    do_clear();
    check_flags("clear0");
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, ^b);
      check_flags("fill");
    end
    check("full_set", bus.full, 1);
    check("overrun_set", bus.overrun, 1);
    do_clear();
    check_flags("clear1");

    // Reset during data bit 4 discards the partial frame.
    bus.serial_in = 1'b0;
    tick(N);
    b = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      bus.serial_in = b[i];
      tick(N);
    end
    bus.serial_in = b[4];
    tick(N / 2);
    check("midframe_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    bus.serial_in = 1'b1;
    tick(3);
    reset_n  = 1'b1;
    exp_addr = '0;
    exp_full = 1'b0;
    exp_ovr  = 1'b0;
    tick(5);
    b = 8'h7E;
    send_frame(b, 1'b1, ^b);
    check_flags("after_reset");

`ifdef CEREAL_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    check_flags("parity_bad");
    send_frame(8'h03, 1'b1, 1'b0);
    check_flags("parity_good");
`endif

    tick(10);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
